// File: rtl/ncore_rst_seq.sv
// ncore_rst_seq: power-up reset sequencer releasing channels in order, with masked warm-reset replay.
module ncore_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int RST_CYCLES  = 5,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk_fr,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              sw_rst_ack,
  output logic              seq_done,
  output logic [1:0]        seq_state
);
  typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, DONE = 2'd2, SW = 2'd3} state_t;
  localparam int MAXC = RST_CYCLES > GAP_CYCLES ? RST_CYCLES : GAP_CYCLES;
  localparam int IW = $clog2(NUM_CH + 1);
  if (CNT_W < 31 && (2 ** CNT_W) - 1 < MAXC) begin : g_cnt_chk
    $error("CNT_W too small for RST_CYCLES/GAP_CYCLES");
  end
  logic [SYNC_STAGES-1:0] sync;
  logic                   irst_n;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NUM_CH-1:0]      out, out_n, pend, pend_n, mask_q, mask_n, low;
  logic                   first, first_n, ack, ack_n, req_q, rise, rst_hit, gap_hit, hold_ph;
  always_ff @(posedge clk_fr or negedge rst)
    if (!rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  assign irst_n  = sync[SYNC_STAGES-1];
  assign rise    = sw_rst_req & ~req_q;
  assign rst_hit = cnt == CNT_W'(RST_CYCLES - 1);
  assign gap_hit = cnt == CNT_W'(GAP_CYCLES - 1);
  assign low     = pend & (~pend + NUM_CH'(1));
  // Nothing released yet in SW means the initial hold still applies.
  assign hold_ph = pend == mask_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    out_n   = out;
    pend_n  = pend;
    mask_n  = mask_q;
    first_n = first;
    ack_n   = 1'b0;
    case (state)
      HOLD:
        if (rst_hit) begin
          state_n = RELEASE;
          out_n   = NUM_CH'(1);
          idx_n   = IW'(1);
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      RELEASE:
        if (idx == IW'(NUM_CH)) state_n = DONE;
        else if (gap_hit) begin
          out_n = out | (NUM_CH'(1) << idx);
          idx_n = idx + 1'b1;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      DONE:
        if (rise) begin
          state_n = SW;
          mask_n  = ch_mask;
          pend_n  = ch_mask;
          first_n = 1'b1;
          cnt_n   = '0;
        end
      SW:
        if (pend == '0) begin
          state_n = DONE;
          ack_n   = 1'b1;
        end else if (first) begin
          out_n   = out & ~pend;
          first_n = 1'b0;
          cnt_n   = '0;
        end else if (hold_ph ? rst_hit : gap_hit) begin
          out_n  = out | low;
          pend_n = pend & ~low;
          cnt_n  = '0;
        end else cnt_n = cnt + 1'b1;
      default: state_n = HOLD;
    endcase
  end
  always_ff @(posedge clk_fr or negedge irst_n)
    if (!irst_n) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      out    <= '0;
      pend   <= '0;
      mask_q <= '0;
      first  <= 1'b0;
      ack    <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      out    <= out_n;
      pend   <= pend_n;
      mask_q <= mask_n;
      first  <= first_n;
      ack    <= ack_n;
      req_q  <= sw_rst_req;
    end
  assign rst_out_n  = out;
  assign sw_rst_ack = ack;
  assign seq_done   = state == DONE;
  assign seq_state  = state;
endmodule

// File: doc/ncore_rst_seq.md
NCORE_RST_SEQ -- requirements
Module: ncore_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sequenced reset outputs (1..32).
REQ-002 SHALL have parameter RST_CYCLES, default 5: hold cycles before the first release (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2: cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: reset-deassert synchroniser depth (>=2).
REQ-005 SHALL have parameter CNT_W, default 8: internal counter width; elaboration error if 2**CNT_W-1 < max(RST_CYCLES, GAP_CYCLES).
REQ-006 SHALL have port clk_fr, input, 1: the single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port sw_rst_req, input, 1: warm-reset request, level, edge-qualified.
REQ-009 SHALL have port ch_mask, input, NUM_CH: channels affected by a warm reset.
REQ-010 SHALL have port rst_out_n, output, NUM_CH: per-channel active-low resets, registered.
REQ-011 SHALL have port sw_rst_ack, output, 1: one-cycle warm-reset completion pulse.
REQ-012 SHALL have port seq_done, output, 1: high while all channels are released and the FSM is idle.
REQ-013 SHALL have port seq_state, output, 2: FSM state (0 HOLD, 1 RELEASE, 2 DONE, 3 SW).

Function
REQ-014 SHALL assert internal reset asynchronously on rst low and deassert it only after SYNC_STAGES posedges of clk_fr with rst high.
REQ-015 SHALL, in HOLD, count RST_CYCLES cycles after internal release, then enter RELEASE.
REQ-016 SHALL, in RELEASE, drive rst_out_n[0] high on the first edge, then each next index GAP_CYCLES edges later, in ascending order.
REQ-017 SHALL enter DONE and raise seq_done one edge after the last channel release.
REQ-018 SHALL detect a warm-reset request in DONE only on the low-to-high transition of registered sw_rst_req; a level held high from an earlier request SHALL NOT retrigger.
REQ-019 SHALL, on accept, capture ch_mask, enter SW, drop seq_done, and drive masked channels low on the next edge.
REQ-020 SHALL leave unmasked channels high throughout SW.
REQ-021 SHALL, in SW, hold masked channels RST_CYCLES cycles, then release them in ascending index order, GAP_CYCLES apart, skipping unmasked indices with no gap.
REQ-022 SHALL pulse sw_rst_ack for exactly one cycle on the edge after the last masked release, return to DONE, and raise seq_done on that same edge.
REQ-023 SHALL, when the captured mask is all-zero, pulse sw_rst_ack on the edge after accept and change no rst_out_n bit.
REQ-024 SHALL ignore sw_rst_req rises in HOLD, RELEASE or SW; ch_mask changes after accept SHALL have no effect.
REQ-025 SHALL never release a channel earlier than its predecessor.
REQ-026 SHALL never generate glitches on rst_out_n: every bit is a flop output.

Reset
REQ-027 SHALL, while internal reset is asserted, force rst_out_n to all-zero, sw_rst_ack to 0, seq_done to 0, seq_state to 0, and all counters and the request-edge register to 0.
REQ-028 SHALL, on rst low during any state including SW, immediately drive all rst_out_n low and restart from HOLD on release; any pending ack SHALL be lost.

Verification (defaults; edge 1 = first posedge after rst rises)
REQ-029 SHALL check power-up: rst_out_n[0..3] rise at edges 7, 9, 11, 13; seq_done and seq_state=2 at edge 14; sw_rst_ack stays 0.
REQ-030 SHALL check a warm reset with ch_mask=4'b1010 at edge 20: bits 1 and 3 go low at 21 and rise at 26 and 28; ack pulses at 29; bits 0 and 2 stay high.
REQ-031 SHALL check ch_mask=0: ack pulses on the edge after accept, rst_out_n stays 4'hF, and seq_done drops for one cycle only.
REQ-032 SHALL check that sw_rst_req held high across ack does not retrigger, and that a low-then-high request is accepted.
REQ-033 SHALL check rst low mid-SW: rst_out_n=0 within the same time step, no ack, and the power-up sequence from REQ-029 repeats.
REQ-034 SHALL check a request during RELEASE: it is ignored, with no ack and an unchanged release schedule.
